// File: rtl/output_drain_stream_if.sv
// Output-memory read port plus result stream bundle for output_drain_stream.
interface output_drain_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output mem_en, mem_we, mem_addr,
    input  mem_dout,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  mem_en, mem_we, mem_addr,
    output mem_dout,
    input  m_data, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/output_drain_stream.sv
// Drains the output memory into a valid/ready stream via a 2-entry FIFO.
// Define DRAIN_STALL_CNT_EN to build the backpressure cycle counter.
module output_drain_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_in,
  output_drain_stream_if.master bus,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  overrun,
  output logic [31:0]           stall_cnt
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT
  } state_t;

  localparam logic [ADDR_WIDTH:0] LAST_ADDR =
    (ADDR_WIDTH+1)'(DEPTH-1);

  state_t state_q, state_d;
  logic done_q, done_d;
  logic [ADDR_WIDTH:0] rd_addr_q, rd_addr_d;
  logic inflight_q, inflight_d;
  logic inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic fifo_last_q [2];
  logic fifo_last_d [2];
  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic drain_done_q, drain_done_d;
  logic overrun_q, overrun_d;

  logic start_w;
  logic valid_w;
  logic last_w;
  logic pop_w;
  logic [2:0] occ_w;
  logic mem_en_w;
  logic is_last_rd_w;

  assign start_w = done_in & ~done_q;
  assign valid_w = (cnt_q != 2'd0);
  assign last_w = valid_w & fifo_last_q[rd_ptr_q];
  assign pop_w = valid_w & bus.m_ready;
  // Slots already claimed: stored words plus the read still in flight.
  assign occ_w = {1'b0, cnt_q} + {2'b0, inflight_q}
               - {2'b0, pop_w};
  assign mem_en_w = (state_q == S_READ) && (occ_w < 3'd2);
  assign is_last_rd_w = (rd_addr_q == LAST_ADDR);

  assign bus.mem_en = mem_en_w;
  assign bus.mem_we = 1'b0;
  assign bus.mem_addr = rd_addr_q[ADDR_WIDTH-1:0];
  assign bus.m_data = fifo_data_q[rd_ptr_q];
  assign bus.m_valid = valid_w;
  assign bus.m_last = last_w;
  assign busy = busy_q;
  assign drain_done = drain_done_q;
  assign overrun = overrun_q;

  always_comb begin
    state_d = state_q;
    done_d = done_in;
    rd_addr_d = rd_addr_q;
    inflight_d = mem_en_w;
    inflight_last_d = mem_en_w & is_last_rd_w;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop_w};
    busy_d = busy_q;
    drain_done_d = 1'b0;
    overrun_d = overrun_q;

    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = bus.mem_dout;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_w) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_w) begin
          state_d = S_READ;
          busy_d = 1'b1;
          rd_addr_d = '0;
          overrun_d = 1'b0;
        end
      end
      S_READ: begin
        if (start_w) overrun_d = 1'b1;
        if (mem_en_w) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (is_last_rd_w) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (start_w) overrun_d = 1'b1;
        if (pop_w && last_w) begin
          state_d = S_IDLE;
          busy_d = 1'b0;
          drain_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q <= 1'b0;
      rd_addr_q <= '0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q <= 2'd0;
      busy_q <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      rd_addr_q <= rd_addr_d;
      inflight_q <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      drain_done_q <= drain_done_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef DRAIN_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start_w) begin
      stall_d = '0;
    end else if (valid_w && !bus.m_ready && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_output_drain_stream.sv
// Directed/randomised bench for output_drain_stream against a queue-based model.
// Define DRAIN_STALL_CNT_EN consistently with the RTL build.
module tb_output_drain_stream;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int DEPTH = 4096;
  localparam int LIMIT = 40000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_in = 1'b0;
  logic busy;
  logic drain_done;
  logic overrun;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  output_drain_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  output_drain_stream #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done_in(done_in),
    .bus(bus),
    .busy(busy),
    .drain_done(drain_done),
    .overrun(overrun),
    .stall_cnt(stall_cnt)
  );

  logic [DW-1:0] mem [DEPTH];
  int en_cnt = 0;
  int we_seen = 0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_dout <= mem[bus.mem_addr];
      en_cnt <= en_cnt + 1;
    end
    if (bus.mem_we) we_seen <= we_seen + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] rx_data[$];
  bit rx_last[$];
  int first_valid, dd_cnt, dd_cyc, last_cyc;
  int unstable, stalls, timeout, en_base;

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  endtask

  function automatic logic [63:0] outs_packed();
    return {bus.mem_en, bus.mem_we, bus.m_valid, bus.m_last,
            busy, drain_done, overrun, 1'b0,
            bus.m_data, 4'h0, bus.mem_addr};
  endfunction

  task automatic drain(input int mode, input int redo_at,
                       input int rst_at);
    bit hold = 0;
    bit redone = 0;
    bit fin = 0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    bit r;
    int p = 0;
    rx_data.delete();
    rx_last.delete();
    first_valid = -1;
    dd_cnt = 0;
    dd_cyc = -1;
    last_cyc = -1;
    unstable = 0;
    stalls = 0;
    timeout = 1;
    en_base = en_cnt;
    @(negedge clk);
    done_in = 1'b1;
    for (int k = 1; k <= LIMIT && !fin; k++) begin
      @(negedge clk);
      done_in = 1'b0;
      if (k == 1) begin
        chk("start_mem_en", bus.mem_en, 1);
        chk("start_busy", busy, 1);
        chk("start_addr0", bus.mem_addr, 0);
      end
      if (bus.m_valid && first_valid < 0) first_valid = k;
      if (hold && !(bus.m_valid && bus.m_data === hd &&
                    bus.m_last === hl)) unstable++;
      if (drain_done) begin
        dd_cnt++;
        dd_cyc = k;
      end
      if (rst_at >= 0 && rx_data.size() == rst_at) begin
        chk("ovr_clr_on_start", overrun, 0);
        rst = 1'b1;
        #1;
        chk("midrun_rst_outs", outs_packed(), 0);
        chk("midrun_rst_stall", stall_cnt, 0);
        timeout = 0;
        return;
      end
      if (redo_at >= 0 && rx_data.size() == redo_at && !redone) begin
        done_in = 1'b1;
        redone = 1;
      end
      if (mode == 0) r = 1;
      else if (mode == 1 && p < 4) r = (p % 2 == 0);
      else r = bit'($urandom_range(0, 1));
      if (bus.m_valid) p++;
      bus.m_ready = r;
      if (bus.m_valid && r) begin
        rx_data.push_back(bus.m_data);
        rx_last.push_back(bus.m_last);
        last_cyc = k;
      end
      if (bus.m_valid && !r) stalls++;
      hold = bus.m_valid && !r;
      hd = bus.m_data;
      hl = bus.m_last;
      if (dd_cnt > 0 && k > dd_cyc + 3) begin
        fin = 1;
        timeout = 0;
      end
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic verify(input string tag, input logic exp_ovr);
    int bad = 0;
    int first_bad = -1;
    int badl = 0;
    logic [31:0] exp_stall;
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_beats"}, rx_data.size(), DEPTH);
    foreach (rx_data[i]) begin
      if (rx_data[i] !== mem[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (rx_last[i] !== (i == DEPTH - 1)) badl++;
    end
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_last_bad"}, badl, 0);
    chk({tag, "_first_valid"}, first_valid, 3);
    chk({tag, "_dd_count"}, dd_cnt, 1);
    chk({tag, "_dd_timing"}, dd_cyc, last_cyc + 1);
    chk({tag, "_mem_en_cycles"}, en_cnt - en_base, DEPTH);
    chk({tag, "_unstable"}, unstable, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_overrun"}, overrun, exp_ovr);
`ifdef DRAIN_STALL_CNT_EN
    exp_stall = 32'(stalls);
`else
    exp_stall = 32'd0;
`endif
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
  endtask

  initial begin
    bus.m_ready = 1'b0;
    fill_mem();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_outs", outs_packed(), 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_no_mem_en", en_cnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_mem_en", en_cnt, 0);
    chk("idle_busy", busy, 0);

    drain(0, -1, -1);
    verify("full_ready", 1'b0);

    fill_mem();
    drain(1, -1, -1);
    verify("toggle_rand", 1'b0);

    fill_mem();
    drain(2, 100, -1);
    verify("overrun", 1'b1);

    fill_mem();
    drain(0, -1, 2000);
    chk("abort_beats", rx_data.size(), 2000);
    repeat (3) @(negedge clk);
    chk("held_rst_outs", outs_packed(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    drain(0, -1, -1);
    verify("after_rst", 1'b0);

    fill_mem();
    drain(2, -1, -1);
    verify("half_ready", 1'b0);

    chk("mem_we_never", we_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
